// File: rtl/ram16m_burst_ctrl.sv
// ram16m_burst_ctrl: single-command burst engine in front of the 16M x 16
// dual-read RAM. Write bursts stream words in over wdata valid/ready and
// drive the RAM write port; read bursts walk RAM read port A and stream
// words out over rdata valid/ready. Port B of the RAM is not touched.
// Optional feature: define RAM16M_BURST_ABORT_EN to add the abort input and
// the aborted pulse output.
module ram16m_burst_ctrl #(
   parameter int AW   = 24,
   parameter int DW   = 16,
   parameter int LENW = 16
) (
   input  logic            clk,
   input  logic            reset,        // asynchronous, active low
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [LENW-1:0] cmd_len,      // words minus one
   input  logic            wdata_valid,
   output logic            wdata_ready,
   input  logic [DW-1:0]   wdata,
   output logic            rdata_valid,
   input  logic            rdata_ready,
   output logic [DW-1:0]   rdata,
   output logic            busy,
   output logic            done,
`ifdef RAM16M_BURST_ABORT_EN
   input  logic            abort,
   output logic            aborted,
`endif
   output logic            mem_wr,
   output logic [AW-1:0]   mem_wr_addr,
   output logic [DW-1:0]   mem_d_in,
   output logic [AW-1:0]   mem_rd_addr,
   input  logic [DW-1:0]   mem_d_out
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WR       = 3'd1;
   localparam logic [2:0] S_WR_LAST  = 3'd2;
   localparam logic [2:0] S_RD       = 3'd3;
   localparam logic [2:0] S_RD_DRAIN = 3'd4;

   logic [2:0]      r_state;
   logic [AW-1:0]   r_cur_addr;
   logic [LENW-1:0] r_remaining;
   logic            r_mem_wr;
   logic [AW-1:0]   r_mem_wr_addr;
   logic [DW-1:0]   r_mem_d_in;
   logic [AW-1:0]   r_mem_rd_addr;
   logic [DW-1:0]   r_rdata;
   logic            r_rdata_valid;
   logic            r_done;
   logic            r_aborted;

   logic            w_abort;
   logic            w_wr_hs;
   logic            w_rd_cap;
   logic            w_last;

`ifdef RAM16M_BURST_ABORT_EN
   // Abort only matters while a burst is in flight.
   assign w_abort = abort && (r_state != S_IDLE);
   assign aborted = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   assign w_wr_hs  = (r_state == S_WR) && wdata_valid && !w_abort;
   assign w_rd_cap = (r_state == S_RD) && (!r_rdata_valid || rdata_ready);
   assign w_last   = (r_remaining == '0);

   // Burst sequencing, RAM port registers and rdata holding register.
   // NOTE: every register here, datapath included, is reset because the
   // RAM-facing outputs and rdata must read 0 the moment reset asserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cur_addr    <= '0;
         r_remaining   <= '0;
         r_mem_wr      <= 1'b0;
         r_mem_wr_addr <= '0;
         r_mem_d_in    <= '0;
         r_mem_rd_addr <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so the defaults below
         // are simply overridden by later assignments in the same cycle.
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_mem_wr  <= w_wr_hs;
         if (rdata_ready && !w_rd_cap) begin
            r_rdata_valid <= 1'b0;
         end

         if (w_abort) begin
            r_state       <= S_IDLE;
            r_mem_wr      <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b1;
            r_aborted     <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (cmd_valid) begin
                     r_cur_addr  <= cmd_addr;
                     r_remaining <= cmd_len;
                     if (cmd_write) begin
                        r_state <= S_WR;
                     end else begin
                        r_mem_rd_addr <= cmd_addr;
                        r_state       <= S_RD;
                     end
                  end
               end
               S_WR: begin
                  if (wdata_valid) begin
                     r_mem_wr_addr <= r_cur_addr;
                     r_mem_d_in    <= wdata;
                     r_cur_addr    <= r_cur_addr + 1'b1;
                     r_remaining   <= r_remaining - 1'b1;
                     if (w_last) begin
                        r_state <= S_WR_LAST;
                     end
                  end
               end
               S_WR_LAST: begin
                  // Final word commits at the end of this cycle.
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               S_RD: begin
                  if (w_rd_cap) begin
                     r_rdata       <= mem_d_out;
                     r_rdata_valid <= 1'b1;
                     r_cur_addr    <= r_cur_addr + 1'b1;
                     r_mem_rd_addr <= r_cur_addr + 1'b1;
                     r_remaining   <= r_remaining - 1'b1;
                     if (w_last) begin
                        r_state <= S_RD_DRAIN;
                     end
                  end
               end
               S_RD_DRAIN: begin
                  if (rdata_ready) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign wdata_ready = (r_state == S_WR);
   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign mem_wr      = r_mem_wr;
   assign mem_wr_addr = r_mem_wr_addr;
   assign mem_d_in    = r_mem_d_in;
   assign mem_rd_addr = r_mem_rd_addr;

endmodule

// File: tb/tb_ram16m_burst_ctrl.sv
// tb_ram16m_burst_ctrl: self-checking bench for ram16m_burst_ctrl. The bench
// plays the RAM (sparse array, combinational read, commit at clock edge) and
// keeps its own record of intended memory contents to predict read data.
module tb_ram16m_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [23:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        wdata_valid, wdata_ready;
   logic [15:0] wdata;
   logic        rdata_valid, rdata_ready;
   logic [15:0] rdata;
   logic        busy, done;
   logic        mem_wr;
   logic [23:0] mem_wr_addr, mem_rd_addr;
   logic [15:0] mem_d_in, mem_d_out;
`ifdef RAM16M_BURST_ABORT_EN
   logic        abort, aborted;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [15:0] ram     [logic [23:0]];
   logic [15:0] ref_mem [logic [23:0]];
   int          ram_gen = 0;

   ram16m_burst_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
      .busy(busy), .done(done),
`ifdef RAM16M_BURST_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_d_in(mem_d_in),
      .mem_rd_addr(mem_rd_addr), .mem_d_out(mem_d_out)
   );

   always #5 clk = ~clk;

   // RAM model: write commits at the edge ending a mem_wr cycle.
   always @(posedge clk) begin
      if (reset && mem_wr) begin
         ram[mem_wr_addr] = mem_d_in;
         ram_gen++;
      end
   end

   // RAM model: read port A is combinational from the address.
   always @(mem_rd_addr or ram_gen) begin
      mem_d_out = ram.exists(mem_rd_addr) ? ram[mem_rd_addr] : 16'hDEAD;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [15:0] ref_word(input logic [23:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'hDEAD;
   endfunction

   task automatic issue_cmd(input logic wr, input logic [23:0] addr, input logic [15:0] len);
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 24'($urandom);
      cmd_len   = 16'($urandom);
      check("busy_after_cmd", {31'd0, busy}, 32'd1);
   endtask

   // Write burst of n words; returns in the cycle that done is seen.
   task automatic write_burst(input logic [23:0] addr, input int n, input logic [15:0] d0,
                              input bit rand_data, input bit gaps);
      logic [15:0] data[$];
      int idx = 0, nwr = 0, last_wr = -100, done_cyc = -1;
      for (int i = 0; i < n; i++) data.push_back(rand_data ? 16'($urandom) : d0 + 16'(i));
      issue_cmd(1'b1, addr, 16'(n - 1));
      for (int k = 0; k < 4 * n + 40; k++) begin
         if (mem_wr) begin
            if (nwr < n) begin
               check("wr_addr", {8'd0, mem_wr_addr}, {8'd0, addr + 24'(nwr)});
               check("wr_data", {16'd0, mem_d_in}, {16'd0, data[nwr]});
               if (!gaps && nwr > 0) check("wr_consecutive", cyc - last_wr, 1);
            end
            last_wr = cyc;
            nwr++;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         wdata_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
         wdata       = (idx < n) ? data[idx] : 16'($urandom);
         if (wdata_valid && wdata_ready) idx++;
         tick();
      end
      wdata_valid = 1'b0;
      check("wr_done_seen", {31'd0, done_cyc >= 0}, 32'd1);
      check("wr_count", nwr, n);
      check("wr_done_latency", done_cyc - last_wr, 1);
      check("wr_busy_at_done", {31'd0, busy}, 32'd0);
      for (int i = 0; i < n; i++) ref_mem[addr + 24'(i)] = data[i];
   endtask

   // Read burst of n words; mode 0 ready held, 1 fixed toggle, 2 random.
   task automatic read_burst(input logic [23:0] addr, input int n, input int mode);
      logic [15:0] got[$];
      int          acc_cyc[$];
      int          done_cyc = -1;
      logic        prev_v = 1'b0, prev_r = 1'b0;
      logic [15:0] prev_d = '0;
      bit          pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      issue_cmd(1'b0, addr, 16'(n - 1));
      for (int k = 0; k < 8 * n + 40; k++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         case (mode)
            0:       rdata_ready = 1'b1;
            1:       rdata_ready = (k < 5) ? pat[k] : 1'b1;
            default: rdata_ready = 1'($urandom_range(0, 1));
         endcase
         if (prev_v && !prev_r) begin
            check("rd_hold_valid", {31'd0, rdata_valid}, 32'd1);
            check("rd_hold_data", {16'd0, rdata}, {16'd0, prev_d});
         end
         if (rdata_valid && rdata_ready) begin
            got.push_back(rdata);
            acc_cyc.push_back(cyc);
         end
         prev_v = rdata_valid;
         prev_r = rdata_ready;
         prev_d = rdata;
         tick();
      end
      rdata_ready = 1'b0;
      check("rd_done_seen", {31'd0, done_cyc >= 0}, 32'd1);
      check("rd_count", got.size(), n);
      for (int i = 0; i < got.size() && i < n; i++) begin
         check("rd_data", {16'd0, got[i]}, {16'd0, ref_word(addr + 24'(i))});
         if (mode == 0 && i > 0) check("rd_consecutive", acc_cyc[i] - acc_cyc[i-1], 1);
      end
      if (acc_cyc.size() > 0) check("rd_done_latency", done_cyc - acc_cyc[acc_cyc.size()-1], 1);
      check("rd_valid_low_at_done", {31'd0, rdata_valid}, 32'd0);
   endtask

   initial begin
      logic [23:0] ra;
      int          rn;
      reset       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      rdata_ready = 1'b0;
`ifdef RAM16M_BURST_ABORT_EN
      abort       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      // Reset state.
      check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      check("rst_wr_addr", {8'd0, mem_wr_addr}, 32'd0);
      check("rst_d_in", {16'd0, mem_d_in}, 32'd0);
      check("rst_rd_addr", {8'd0, mem_rd_addr}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      reset = 1'b1;
      tick();

      // Directed write then read of 0x10..0x13.
      write_burst(24'h000010, 4, 16'hA000, 1'b0, 1'b0);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_idle_after_wr", {31'd0, busy}, 32'd0);
      read_burst(24'h000010, 4, 0);
      tick();

      // Backpressure: three words with ready pattern 1,0,0,1,1.
      read_burst(24'h000010, 3, 1);
      tick();

      // Address wrap across the top of the address space.
      write_burst(24'hFFFFFE, 4, 16'h0, 1'b1, 1'b0);
      read_burst(24'hFFFFFE, 4, 2);
      tick();

      // Reset in the middle of a 5-word write after 2 words accepted.
      issue_cmd(1'b1, 24'h000100, 16'd4);
      wdata_valid = 1'b1;
      wdata       = 16'hB000;
      tick();
      wdata       = 16'hB001;
      tick();
      reset       = 1'b0;
      wdata_valid = 1'b0;
      #1;
      check("mid_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      check("mid_rst_wr_addr", {8'd0, mem_wr_addr}, 32'd0);
      check("mid_rst_d_in", {16'd0, mem_d_in}, 32'd0);
      check("mid_rst_rd_addr", {8'd0, mem_rd_addr}, 32'd0);
      check("mid_rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_done_after_rst", {31'd0, done}, 32'd0);
         check("idle_after_rst", {31'd0, busy}, 32'd0);
      end
      write_burst(24'h000200, 3, 16'h0, 1'b1, 1'b0);
      read_burst(24'h000200, 3, 0);
      tick();

      // Random bursts, each read issued in the same cycle as the write's done.
      for (int it = 0; it < 6; it++) begin
         ra = 24'($urandom);
         rn = (it == 0) ? 1 : $urandom_range(1, 10);
         write_burst(ra, rn, 16'h0, 1'b1, 1'b1);
         read_burst(ra, rn, 2);
      end
      tick();

`ifdef RAM16M_BURST_ABORT_EN
      // Abort while the second word of an 8-word read is presented.
      write_burst(24'h000300, 8, 16'h0, 1'b1, 1'b0);
      tick();
      issue_cmd(1'b0, 24'h000300, 16'd7);
      rdata_ready = 1'b1;
      begin
         int seen = 0;
         for (int k = 0; k < 20 && seen < 2; k++) begin
            if (rdata_valid) seen++;
            if (seen < 2) tick();
         end
         check("abort_word2_reached", seen, 2);
         check("abort_word2_data", {16'd0, rdata}, {16'd0, ref_word(24'h000301)});
      end
      abort = 1'b1;
      tick();
      abort       = 1'b0;
      rdata_ready = 1'b0;
      check("abort_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd1);
      check("abort_aborted", {31'd0, aborted}, 32'd1);
      check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      check("abort_done_pulse", {31'd0, done}, 32'd0);
      check("abort_aborted_pulse", {31'd0, aborted}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
